// File: rtl/calc_button_debouncer.sv
// rtl/calc_button_debouncer.sv - keypad debouncer producing one-cycle one-hot press events (optional CALC_BUTTON_REPEAT_EN auto-repeat)

package calc_pkg;
   // Keypad levels, one bit per key; num_0 is bit 0, on_off is the MSB.
   typedef struct packed {
      logic on_off;
      logic clear;
      logic equals;
      logic op_div;
      logic op_mul;
      logic op_sub;
      logic op_add;
      logic dot;
      logic num_9;
      logic num_8;
      logic num_7;
      logic num_6;
      logic num_5;
      logic num_4;
      logic num_3;
      logic num_2;
      logic num_1;
      logic num_0;
   } buttons_t;

   localparam int BtnOnOff = 17;
endpackage

module calc_button_debouncer #(
   parameter int DebounceCycles = 1000,
   parameter int RepeatDelay    = 500000,
   parameter int RepeatPeriod   = 100000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  calc_pkg::buttons_t buttons_i,
   output calc_pkg::buttons_t buttons_o,
   output logic               pressed_o
);

   localparam int NB     = $bits(calc_pkg::buttons_t);
   localparam int MaxRep = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
   localparam int MaxCnt = (DebounceCycles > MaxRep) ? DebounceCycles : MaxRep;
   localparam int CntW   = $clog2(MaxCnt + 1);

   localparam logic [CntW-1:0] DebLast = CntW'(DebounceCycles - 1);
   localparam logic [CntW-1:0] CntMax  = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESS_WAIT,
      S_HELD,
      S_RELEASE_WAIT
   } state_t;

   logic [NB-1:0]   r_sync1;
   logic [NB-1:0]   r_sync2;
   state_t          r_state;
   logic [CntW-1:0] r_cnt;
   logic [NB-1:0]   r_cand;
   logic [NB-1:0]   r_out;

   logic [NB-1:0]   w_s;
   logic            w_one_hot;
   logic            w_zero;
   logic [CntW-1:0] w_cnt_inc;

   assign w_s       = r_sync2;
   assign w_one_hot = ($countones(w_s) == 1);
   assign w_zero    = (w_s == '0);
   // Counters hold at all-ones instead of wrapping back to zero.
   assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + 1'b1;

`ifdef CALC_BUTTON_REPEAT_EN
   logic [CntW-1:0] r_rep_cnt;
   logic            r_rep_first;
   logic [CntW-1:0] w_rep_last;
   logic [CntW-1:0] w_rep_inc;
   logic            w_rep_allowed;

   // First repeat waits the long delay, later ones use the shorter period.
   assign w_rep_last    = r_rep_first ? CntW'(RepeatDelay - 1) : CntW'(RepeatPeriod - 1);
   assign w_rep_inc     = (r_rep_cnt == CntMax) ? r_rep_cnt : r_rep_cnt + 1'b1;
   // The power key must never fire twice from one hold.
   assign w_rep_allowed = ~r_cand[calc_pkg::BtnOnOff];
`endif

   // Two-flop synchronizer for the asynchronous keypad levels.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= buttons_i;
         r_sync2 <= r_sync1;
      end
   end

   // Shared debounce FSM: one accepted key at a time, one-cycle event pulse on acceptance.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_cand  <= '0;
         r_out   <= '0;
`ifdef CALC_BUTTON_REPEAT_EN
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b1;
`endif
      end else begin
         r_out <= '0;
         case (r_state)
            S_IDLE: begin
               // Zero or several keys down: nothing to evaluate yet.
               if (w_one_hot) begin
                  r_cand  <= w_s;
                  r_cnt   <= '0;
                  r_state <= S_PRESS_WAIT;
               end
            end
            S_PRESS_WAIT: begin
               if (w_s != r_cand) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == DebLast) begin
                  r_out   <= r_cand;
                  r_state <= S_HELD;
`ifdef CALC_BUTTON_REPEAT_EN
                  r_rep_cnt   <= '0;
                  r_rep_first <= 1'b1;
`endif
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_HELD: begin
               // Only a full release matters here; extra keys are ignored.
               if (w_zero) begin
                  r_cnt   <= '0;
                  r_state <= S_RELEASE_WAIT;
               end
`ifdef CALC_BUTTON_REPEAT_EN
               else if (w_rep_allowed) begin
                  if (r_rep_cnt == w_rep_last) begin
                     r_out       <= r_cand;
                     r_rep_cnt   <= '0;
                     r_rep_first <= 1'b0;
                  end else begin
                     r_rep_cnt <= w_rep_inc;
                  end
               end
`endif
            end
            S_RELEASE_WAIT: begin
               // Repeat counter is left untouched so a bounce back resumes it.
               if (!w_zero) begin
                  r_cnt   <= '0;
                  r_state <= S_HELD;
               end else if (r_cnt == DebLast) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign buttons_o = calc_pkg::buttons_t'(r_out);
   assign pressed_o = (r_state == S_HELD) || (r_state == S_RELEASE_WAIT);

endmodule
